calc_key_sequencer: RTL and testbench

- Upstream stage of the BCD add/subtract unit. Turns a stream of decoded keypad codes into two 4-digit BCD operands, an operation code and a one-cycle execute strobe.
- Latches the arithmetic result back for display and for operation chaining.
- Sits between the keypad scanner/debouncer and the BCD arithmetic stage. Also drives the 7-segment display mux.

---
 rtl/calc_pkg.sv | 33 +++
 rtl/calc_key_sequencer_if.sv | 27 ++
 rtl/bcd_digit_reg.sv | 67 ++++++
 rtl/calc_key_sequencer.sv | 134 +++++++++++++
 tb/tb_calc_key_sequencer.sv | 178 +++++++++++++++++
 5 files changed

// File: rtl/calc_pkg.sv
// Shared definitions for the calculator key sequencer: key codes, operation
// encodings, FSM states and digit-register commands.
package calc_pkg;

  localparam logic [3:0] KEY_PLUS  = 4'hA;
  localparam logic [3:0] KEY_MINUS = 4'hB;
  localparam logic [3:0] KEY_EQ    = 4'hC;
  localparam logic [3:0] KEY_BS    = 4'hE;
  localparam logic [3:0] KEY_CLR   = 4'hF;

  localparam logic [1:0] OP_NONE = 2'b00;
  localparam logic [1:0] OP_ADD  = 2'b01;
  localparam logic [1:0] OP_SUB  = 2'b10;

  typedef enum logic [1:0] {S_A, S_B, S_EXEC, S_RES} state_t;

  typedef enum logic [2:0] {
    REG_HOLD, REG_CLR, REG_SHIFT, REG_BS, REG_LOAD, REG_START
  } reg_op_t;

  function automatic logic is_digit(input logic [3:0] k);
    return k <= 4'd9;
  endfunction

  function automatic logic is_operator(input logic [3:0] k);
    return (k == KEY_PLUS) || (k == KEY_MINUS);
  endfunction

  function automatic logic [1:0] key_to_op(input logic [3:0] k);
    return (k == KEY_PLUS) ? OP_ADD : OP_SUB;
  endfunction

endpackage

// File: rtl/calc_key_sequencer_if.sv
// Keypad, arithmetic-stage and display signals of the key sequencer.
// master = environment side, slave = sequencer side.
interface calc_key_sequencer_if #(parameter int NUM_DIGITS = 4);
  localparam int W = 4 * NUM_DIGITS;

  logic         key_valid;
  logic [3:0]   key_code;
  logic         key_ready;
  logic [W-1:0] resultado;
  logic         operacion_valida;
  logic [W-1:0] numero_1;
  logic [W-1:0] numero_2;
  logic [1:0]   suma_resta;
  logic         igual_en;
  logic [W-1:0] display_bcd;
  logic         error;

  modport master (
    output key_valid, key_code, resultado, operacion_valida,
    input  key_ready, numero_1, numero_2, suma_resta, igual_en, display_bcd, error
  );

  modport slave (
    input  key_valid, key_code, resultado, operacion_valida,
    output key_ready, numero_1, numero_2, suma_resta, igual_en, display_bcd, error
  );
endinterface

// File: rtl/bcd_digit_reg.sv
// BCD operand register with saturating digit counter: shift-in, backspace,
// clear, full load and single-digit start.
module bcd_digit_reg
  import calc_pkg::*;
#(
  parameter int NUM_DIGITS = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  reg_op_t                 op_i,
  input  logic [3:0]              digit_i,
  input  logic [4*NUM_DIGITS-1:0] load_i,
  output logic [4*NUM_DIGITS-1:0] value_o,
  output logic [4*NUM_DIGITS-1:0] value_d_o,
  output logic                    empty_o,
  output logic                    empty_d_o
);
  localparam int W  = 4 * NUM_DIGITS;
  localparam int CW = $clog2(NUM_DIGITS + 1);
  localparam logic [CW-1:0] FULL = CW'(NUM_DIGITS);

  logic [W-1:0]  value_q, value_d;
  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    value_d = value_q;
    cnt_d   = cnt_q;
    case (op_i)
      REG_CLR: begin
        value_d = '0;
        cnt_d   = '0;
      end
      REG_SHIFT: if (cnt_q < FULL) begin
        value_d = {value_q[W-5:0], digit_i};
        cnt_d   = cnt_q + 1'b1;
      end
      REG_BS: if (cnt_q != '0) begin
        value_d = {4'h0, value_q[W-1:4]};
        cnt_d   = cnt_q - 1'b1;
      end
      REG_LOAD: begin
        value_d = load_i;
        cnt_d   = FULL;
      end
      REG_START: begin
        value_d = {{(W-4){1'b0}}, digit_i};
        cnt_d   = CW'(1);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      value_q <= '0;
      cnt_q   <= '0;
    end else begin
      value_q <= value_d;
      cnt_q   <= cnt_d;
    end
  end

  assign value_o   = value_q;
  assign value_d_o = value_d;
  assign empty_o   = (cnt_q == '0);
  assign empty_d_o = (cnt_d == '0);
endmodule

// File: rtl/calc_key_sequencer.sv
// Keypad-to-operand sequencer feeding the BCD add/subtract stage.
// Optional backspace key enabled by defining CALC_BACKSPACE_EN.
module calc_key_sequencer
  import calc_pkg::*;
#(
  parameter int NUM_DIGITS = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  calc_key_sequencer_if.slave  bus
);
  localparam int W = 4 * NUM_DIGITS;

  state_t       state_q, state_d;
  logic [1:0]   op_q, op_d;
  logic         err_q, err_d;
  logic [W-1:0] disp_q, disp_d;
  logic         igual_q, ready_q;

  reg_op_t      a_op, b_op;
  logic [W-1:0] a_q, a_d, b_q, b_d;
  logic         b_empty_q, b_empty_d;
  logic         a_unused_empty, a_unused_empty_d;
  logic         key_acc;
  logic [3:0]   k;

  assign k       = bus.key_code;
  assign key_acc = bus.key_valid && (state_q != S_EXEC);

  bcd_digit_reg #(.NUM_DIGITS(NUM_DIGITS)) u_reg_a (
    .clk(clk), .reset(reset), .op_i(a_op), .digit_i(k), .load_i(bus.resultado),
    .value_o(a_q), .value_d_o(a_d), .empty_o(a_unused_empty), .empty_d_o(a_unused_empty_d)
  );

  bcd_digit_reg #(.NUM_DIGITS(NUM_DIGITS)) u_reg_b (
    .clk(clk), .reset(reset), .op_i(b_op), .digit_i(k), .load_i('0),
    .value_o(b_q), .value_d_o(b_d), .empty_o(b_empty_q), .empty_d_o(b_empty_d)
  );

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    err_d   = err_q;
    a_op    = REG_HOLD;
    b_op    = REG_HOLD;

    // The result is tracked every cycle while it is on display.
    if (state_q == S_RES) err_d = ~bus.operacion_valida;

    if (state_q == S_EXEC) begin
      state_d = S_RES;
    end else if (key_acc) begin
      if (k == KEY_CLR) begin
        state_d = S_A;
        op_d    = OP_NONE;
        err_d   = 1'b0;
        a_op    = REG_CLR;
        b_op    = REG_CLR;
      end else begin
        case (state_q)
          S_A: begin
            if (is_digit(k)) a_op = REG_SHIFT;
            else if (is_operator(k)) begin
              op_d    = key_to_op(k);
              b_op    = REG_CLR;
              state_d = S_B;
            end
`ifdef CALC_BACKSPACE_EN
            else if (k == KEY_BS) a_op = REG_BS;
`endif
          end
          S_B: begin
            if (is_digit(k)) b_op = REG_SHIFT;
            else if (is_operator(k) && b_empty_q) op_d = key_to_op(k);
            else if ((k == KEY_EQ) && !b_empty_q) state_d = S_EXEC;
`ifdef CALC_BACKSPACE_EN
            else if ((k == KEY_BS) && !b_empty_q) b_op = REG_BS;
`endif
          end
          S_RES: begin
            if (is_digit(k)) begin
              a_op    = REG_START;
              b_op    = REG_CLR;
              op_d    = OP_NONE;
              err_d   = 1'b0;
              state_d = S_A;
            end else if (is_operator(k) && bus.operacion_valida) begin
              // Chain: the previous result becomes the new first operand.
              a_op    = REG_LOAD;
              b_op    = REG_CLR;
              op_d    = key_to_op(k);
              state_d = S_B;
            end
          end
          default: ;
        endcase
      end
    end

    // Display follows the post-edge values so it lines up with the operands.
    case (state_d)
      S_A:     disp_d = a_d;
      S_B:     disp_d = b_empty_d ? a_d : b_d;
      S_RES:   disp_d = (state_q == S_RES) ? bus.resultado : disp_q;
      default: disp_d = disp_q;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_A;
      op_q    <= OP_NONE;
      err_q   <= 1'b0;
      disp_q  <= '0;
      igual_q <= 1'b0;
      ready_q <= 1'b1;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      err_q   <= err_d;
      disp_q  <= disp_d;
      igual_q <= (state_d == S_EXEC);
      ready_q <= (state_d != S_EXEC);
    end
  end

  assign bus.numero_1    = a_q;
  assign bus.numero_2    = b_q;
  assign bus.suma_resta  = op_q;
  assign bus.igual_en    = igual_q;
  assign bus.key_ready   = ready_q;
  assign bus.display_bcd = disp_q;
  assign bus.error       = err_q;
endmodule

// File: tb/tb_calc_key_sequencer.sv
// Directed self-checking bench for calc_key_sequencer; expected values are
// hand-computed, with the backspace case chosen on CALC_BACKSPACE_EN.
module tb_calc_key_sequencer;
  import calc_pkg::*;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  calc_key_sequencer_if #(.NUM_DIGITS(4)) bus ();

  calc_key_sequencer #(.NUM_DIGITS(4)) dut (
    .clk(clk), .reset(reset), .bus(bus.slave)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int pulses   = 0;
  int long_pulses = 0;
  logic igual_prev = 1'b0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Called at a falling edge: key is sampled by the next rising edge.
  task automatic press(input logic [3:0] code);
    bus.key_valid = 1'b1;
    bus.key_code  = code;
    @(negedge clk);
    bus.key_valid = 1'b0;
    bus.key_code  = 4'h0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  always @(negedge clk) begin
    if (bus.igual_en === 1'b1) begin
      pulses++;
      if (igual_prev) long_pulses++;
    end
    igual_prev = (bus.igual_en === 1'b1);
  end

  initial begin
    reset = 1'b1;
    bus.key_valid = 1'b0;
    bus.key_code = 4'h0;
    bus.resultado = 16'h0046;
    bus.operacion_valida = 1'b1;
    idle(2);
    check_eq("rst_n1", bus.numero_1, 16'h0000);
    check_eq("rst_n2", bus.numero_2, 16'h0000);
    check_eq("rst_op", bus.suma_resta, 2'b00);
    check_eq("rst_igual", bus.igual_en, 1'b0);
    check_eq("rst_disp", bus.display_bcd, 16'h0000);
    check_eq("rst_err", bus.error, 1'b0);
    check_eq("rst_ready", bus.key_ready, 1'b1);
    reset = 1'b0;
    idle(1);

    // 12 + 34 =
    press(4'd1); press(4'd2);
    check_eq("t1_dispA", bus.display_bcd, 16'h0012);
    press(KEY_PLUS);
    check_eq("t1_op", bus.suma_resta, OP_ADD);
    check_eq("t1_dispA_b0", bus.display_bcd, 16'h0012);
    press(4'd3); press(4'd4);
    check_eq("t1_dispB", bus.display_bcd, 16'h0034);
    press(KEY_EQ);
    check_eq("t1_igual", bus.igual_en, 1'b1);
    check_eq("t1_ready", bus.key_ready, 1'b0);
    check_eq("t1_n1", bus.numero_1, 16'h0012);
    check_eq("t1_n2", bus.numero_2, 16'h0034);
    check_eq("t1_op_exec", bus.suma_resta, OP_ADD);
    idle(1);
    check_eq("t1_igual_off", bus.igual_en, 1'b0);
    check_eq("t1_disp_hold", bus.display_bcd, 16'h0034);
    idle(1);
    check_eq("t1_disp_res", bus.display_bcd, 16'h0046);
    check_eq("t1_err", bus.error, 1'b0);

    // Chain from result: - 6 =
    press(KEY_MINUS);
    check_eq("t4_n1", bus.numero_1, 16'h0046);
    check_eq("t4_op", bus.suma_resta, OP_SUB);
    check_eq("t4_n2clr", bus.numero_2, 16'h0000);
    press(4'd6);
    check_eq("t4_n2", bus.numero_2, 16'h0006);
    press(KEY_EQ);
    check_eq("t4_igual", bus.igual_en, 1'b1);
    idle(1);
    bus.resultado = 16'h0040;
    bus.operacion_valida = 1'b0;
    idle(1);
    check_eq("t4_err", bus.error, 1'b1);
    check_eq("t4_disp", bus.display_bcd, 16'h0040);
    press(KEY_PLUS);
    check_eq("t4_ign_op", bus.suma_resta, OP_SUB);
    check_eq("t4_ign_n1", bus.numero_1, 16'h0046);
    check_eq("t4_err_keep", bus.error, 1'b1);

    // Clear, then five digits
    press(KEY_CLR);
    bus.resultado = 16'h0046;
    bus.operacion_valida = 1'b1;
    check_eq("t2_clr_n1", bus.numero_1, 16'h0000);
    check_eq("t2_clr_op", bus.suma_resta, OP_NONE);
    check_eq("t2_clr_err", bus.error, 1'b0);
    check_eq("t2_clr_disp", bus.display_bcd, 16'h0000);
    press(4'd1); press(4'd2); press(4'd3); press(4'd4); press(4'd5);
    check_eq("t2_n1", bus.numero_1, 16'h1234);
    check_eq("t2_disp", bus.display_bcd, 16'h1234);
    press(KEY_EQ);
    check_eq("t2_eq_ign", bus.key_ready, 1'b1);
    press(4'hD);
    check_eq("t2_rsv", bus.numero_1, 16'h1234);

    // 9 + - 2 =
    press(KEY_CLR);
    press(4'd9); press(KEY_PLUS); press(KEY_MINUS);
    check_eq("t3_op", bus.suma_resta, OP_SUB);
    press(4'd2);
    press(KEY_MINUS);
    check_eq("t3_op_locked", bus.suma_resta, OP_SUB);
    press(KEY_EQ);
    check_eq("t3_igual", bus.igual_en, 1'b1);
    check_eq("t3_n2", bus.numero_2, 16'h0002);
    check_eq("t3_n1", bus.numero_1, 16'h0009);
    idle(1);

    // Key during the execute cycle is dropped
    press(KEY_CLR);
    press(4'd1); press(KEY_PLUS); press(4'd2); press(KEY_EQ);
    check_eq("t5_ready", bus.key_ready, 1'b0);
    press(4'd7);
    check_eq("t5_n2", bus.numero_2, 16'h0002);
    check_eq("t5_n1", bus.numero_1, 16'h0001);

    // Reset in the middle of the execute cycle
    press(KEY_CLR);
    press(4'd1); press(KEY_PLUS); press(4'd2); press(KEY_EQ);
    check_eq("t5b_igual", bus.igual_en, 1'b1);
    #2 reset = 1'b1;
    #1;
    check_eq("t5b_igual_rst", bus.igual_en, 1'b0);
    check_eq("t5b_n1", bus.numero_1, 16'h0000);
    check_eq("t5b_n2", bus.numero_2, 16'h0000);
    check_eq("t5b_op", bus.suma_resta, OP_NONE);
    check_eq("t5b_ready", bus.key_ready, 1'b1);
    @(negedge clk);
    reset = 1'b0;
    idle(1);

    // Backspace
    press(4'd5); press(4'd6); press(KEY_BS); press(4'd7);
`ifdef CALC_BACKSPACE_EN
    check_eq("t6_bs", bus.numero_1, 16'h0057);
`else
    check_eq("t6_bs", bus.numero_1, 16'h0567);
`endif
    press(KEY_PLUS); press(KEY_BS);
    check_eq("t6_bs_b0_op", bus.suma_resta, OP_ADD);
    check_eq("t6_bs_b0_n2", bus.numero_2, 16'h0000);

    check_eq("igual_pulses", pulses, 5);
    check_eq("igual_width", long_pulses, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
